// File: rtl/mic_frame_collector.sv
// Purpose : double-buffered packer of decimated ADC samples into N_SAMPLES-slot frames.
// Latency : accept -> fill_level 1 cycle; completing sample -> frame_valid/frame_out 1 cycle.
// Backpres: none toward the ADC; a frame completed while the read bank is still held is dropped and counted.
//
// Ports:
//   adc_clk, reset         clock and synchronous active-high reset
//   sample_in/sample_valid raw microphone sample stream
//   frame_ack              consumer has taken the presented frame
//   frame_out/frame_valid  presented frame (slot 0 oldest) and its valid flag
//   frame_seq              sequence number of the presented frame (wraps)
//   fill_level             samples currently in the write bank
//   overflow_count         dropped frames, saturating
module mic_frame_collector #(
    parameter int N_SAMPLES    = 8,
    parameter int SAMPLE_WIDTH = 32,
    parameter int DECIMATE     = 1
) (
    input  logic                                adc_clk,
    input  logic                                reset,
    input  logic [SAMPLE_WIDTH-1:0]             sample_in,
    input  logic                                sample_valid,
    input  logic                                frame_ack,
    output logic [N_SAMPLES*SAMPLE_WIDTH-1:0]   frame_out,
    output logic                                frame_valid,
    output logic [7:0]                          frame_seq,
    output logic [$clog2(N_SAMPLES+1)-1:0]      fill_level,
    output logic [15:0]                         overflow_count
);

    localparam int IW = $clog2(N_SAMPLES);
    localparam int FW = $clog2(N_SAMPLES + 1);
    localparam int DW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(N_SAMPLES - 1);
    localparam logic [DW-1:0] DEC_LAST  = DW'(DECIMATE - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [DW-1:0]     dec_cnt_q, dec_cnt_d;
    logic [7:0]        seq_q, seq_d;
    // Number given to the next swapped-in frame; lets the first frame carry 0.
    logic [7:0]        next_seq_q, next_seq_d;
    logic [15:0]       ovf_q, ovf_d;

    logic [SAMPLE_WIDTH-1:0] bank_q [2][N_SAMPLES];

    logic accept;
    logic complete;
    logic swap;
    logic rd_bank;

    // The sample path depends only on sample_valid and local counters;
    // frame_ack enters solely through the swap/drop decision.
    assign accept   = sample_valid && (dec_cnt_q == '0);
    assign complete = accept && (fill_q == FILL_LAST);
    assign swap     = complete && ((state_q == ST_EMPTY) || frame_ack);
    assign rd_bank  = ~wr_bank_q;

    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        fill_d     = fill_q;
        dec_cnt_d  = dec_cnt_q;
        seq_d      = seq_q;
        next_seq_d = next_seq_q;
        ovf_d      = ovf_q;

        if (sample_valid) begin
            dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + DW'(1);
        end

        if (accept) begin
            fill_d = fill_q + FW'(1);
        end

        if (complete) begin
            // Either way the write bank restarts; a drop simply overwrites it.
            fill_d = '0;
            if (swap) begin
                wr_bank_d  = ~wr_bank_q;
                state_d    = ST_HELD;
                seq_d      = next_seq_q;
                next_seq_d = next_seq_q + 8'd1;
            end else if (ovf_q != 16'hFFFF) begin
                ovf_d = ovf_q + 16'd1;
            end
        end else if ((state_q == ST_HELD) && frame_ack) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            wr_bank_q  <= 1'b0;
            fill_q     <= '0;
            dec_cnt_q  <= '0;
            seq_q      <= 8'd0;
            next_seq_q <= 8'd0;
            ovf_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            fill_q     <= fill_d;
            dec_cnt_q  <= dec_cnt_d;
            seq_q      <= seq_d;
            next_seq_q <= next_seq_d;
            ovf_q      <= ovf_d;
        end
    end

    // Bank storage carries no reset; contents are only observed once a frame is held.
    always_ff @(posedge adc_clk) begin
        if (accept && !reset) begin
            bank_q[wr_bank_q][fill_q[IW-1:0]] <= sample_in;
        end
    end

    always_comb begin
        for (int k = 0; k < N_SAMPLES; k++) begin
            frame_out[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = bank_q[rd_bank][k];
        end
    end

    assign frame_valid    = (state_q == ST_HELD);
    assign frame_seq      = seq_q;
    assign fill_level     = fill_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_mic_frame_collector.sv
module tb_mic_frame_collector;

    localparam int N = 8;
    localparam int W = 32;

    logic           adc_clk = 1'b0;
    logic           reset = 1'b1;
    logic [W-1:0]   sample_in = '0;
    logic           sample_valid = 1'b0;
    logic           frame_ack = 1'b0;

    logic [N*W-1:0] fo1, fo4;
    logic           fv1, fv4;
    logic [7:0]     fs1, fs4;
    logic [3:0]     fl1, fl4;
    logic [15:0]    oc1, oc4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 adc_clk = ~adc_clk;

    mic_frame_collector #(.N_SAMPLES(N), .SAMPLE_WIDTH(W), .DECIMATE(1)) dut1 (
        .adc_clk(adc_clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .frame_ack(frame_ack), .frame_out(fo1), .frame_valid(fv1), .frame_seq(fs1),
        .fill_level(fl1), .overflow_count(oc1));

    mic_frame_collector #(.N_SAMPLES(N), .SAMPLE_WIDTH(W), .DECIMATE(4)) dut4 (
        .adc_clk(adc_clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .frame_ack(frame_ack), .frame_out(fo4), .frame_valid(fv4), .frame_seq(fs4),
        .fill_level(fl4), .overflow_count(oc4));

    // Reference model: index 0 mirrors DECIMATE=1, index 1 mirrors DECIMATE=4.
    bit             m_vld  [2];
    int             m_fill [2];
    int             m_vcnt [2];
    int             m_seq  [2];
    int             m_nseq [2];
    int             m_ovf  [2];
    logic [W-1:0]   m_pend [2][N];
    logic [N*W-1:0] m_frame[2];

    function automatic void model_step(int m, bit rst, bit sv, logic [W-1:0] sin, bit ack);
        int  d    = (m == 0) ? 1 : 4;
        bit  acc;
        bit  done = 1'b0;
        if (rst) begin
            m_vld[m] = 1'b0; m_fill[m] = 0; m_vcnt[m] = 0;
            m_seq[m] = 0; m_nseq[m] = 0; m_ovf[m] = 0;
            return;
        end
        acc = sv && (m_vcnt[m] == 0);
        if (sv) m_vcnt[m] = (m_vcnt[m] + 1) % d;
        if (acc) begin
            m_pend[m][m_fill[m]] = sin;
            m_fill[m]++;
            if (m_fill[m] == N) begin
                done = 1'b1;
                m_fill[m] = 0;
            end
        end
        if (done) begin
            if (!m_vld[m] || ack) begin
                for (int k = 0; k < N; k++) m_frame[m][k*W +: W] = m_pend[m][k];
                m_vld[m] = 1'b1;
                m_seq[m] = m_nseq[m] % 256;
                m_nseq[m]++;
            end else if (m_ovf[m] < 65535) begin
                m_ovf[m]++;
            end
        end else if (ack) begin
            m_vld[m] = 1'b0;
        end
    endfunction

    task automatic chk(string nm, logic [N*W-1:0] act, logic [N*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_check();
        chk("d1_valid", {255'd0, fv1}, m_vld[0]);
        chk("d1_fill",  {252'd0, fl1}, m_fill[0]);
        chk("d1_seq",   {248'd0, fs1}, m_seq[0]);
        chk("d1_ovf",   {240'd0, oc1}, m_ovf[0]);
        if (m_vld[0]) chk("d1_frame", fo1, m_frame[0]);
        chk("d4_valid", {255'd0, fv4}, m_vld[1]);
        chk("d4_fill",  {252'd0, fl4}, m_fill[1]);
        chk("d4_seq",   {248'd0, fs4}, m_seq[1]);
        chk("d4_ovf",   {240'd0, oc4}, m_ovf[1]);
        if (m_vld[1]) chk("d4_frame", fo4, m_frame[1]);
    endtask

    // Drive one cycle of inputs, advance the model, sample outputs 1 time unit after the edge.
    task automatic step(bit rst, bit sv, logic [W-1:0] sin, bit ack);
        reset = rst; sample_valid = sv; sample_in = sin; frame_ack = ack;
        model_step(0, rst, sv, sin, ack);
        model_step(1, rst, sv, sin, ack);
        @(posedge adc_clk);
        #1;
        model_check();
    endtask

    typedef struct {
        bit rst; bit sv; int sin; bit ack;
        bit e_vld; int e_fill; int e_seq; int e_ovf; int e_s0; int e_s7;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // Fill-and-present then ack-and-refill, DECIMATE=1, hand-derived expectations.
        vecs[0] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        for (int k = 1; k <= 8; k++)
            vecs[k] = '{1'b0, 1'b1, k, 1'b0, (k == 8), k % 8, 0, 0, 1, 8};
        vecs[9] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        for (int k = 10; k <= 17; k++)
            vecs[k] = '{1'b0, 1'b1, k - 1, 1'b0, (k == 17), (k - 9) % 8, 1, 0, 9, 16};

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rst, vecs[i].sv, vecs[i].sin, vecs[i].ack);
            chk($sformatf("tbl%0d_valid", i), {255'd0, fv1}, vecs[i].e_vld);
            chk($sformatf("tbl%0d_fill", i),  {252'd0, fl1}, vecs[i].e_fill);
            chk($sformatf("tbl%0d_ovf", i),   {240'd0, oc1}, vecs[i].e_ovf);
            if (vecs[i].e_vld) begin
                chk($sformatf("tbl%0d_seq", i),   {248'd0, fs1}, vecs[i].e_seq);
                chk($sformatf("tbl%0d_slot0", i), {224'd0, fo1[0 +: W]}, vecs[i].e_s0);
                chk($sformatf("tbl%0d_slot7", i), {224'd0, fo1[7*W +: W]}, vecs[i].e_s7);
            end
        end

        // Overflow: frame 0 held un-acked while three more frames complete.
        step(1'b1, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 32; k++) step(1'b0, 1'b1, k, 1'b0);
        chk("ovf_valid", {255'd0, fv1}, 1);
        chk("ovf_count", {240'd0, oc1}, 3);
        chk("ovf_seq",   {248'd0, fs1}, 0);
        for (int k = 0; k < N; k++)
            chk($sformatf("ovf_slot%0d", k), {224'd0, fo1[k*W +: W]}, k + 1);

        // Ack in the same cycle as the completing sample: valid never drops.
        step(1'b1, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, k, 1'b0);
        for (int k = 9; k <= 16; k++) begin
            step(1'b0, 1'b1, k, (k == 16));
            chk($sformatf("simul_vld_%0d", k), {255'd0, fv1}, 1);
        end
        chk("simul_seq", {248'd0, fs1}, 1);
        chk("simul_ovf", {240'd0, oc1}, 0);
        for (int k = 0; k < N; k++)
            chk($sformatf("simul_slot%0d", k), {224'd0, fo1[k*W +: W]}, k + 9);

        // Decimation by 4: first frame holds 0,4,...,28.
        step(1'b1, 1'b0, 0, 1'b0);
        for (int k = 0; k < 32; k++) step(1'b0, 1'b1, k, 1'b0);
        chk("dec_valid", {255'd0, fv4}, 1);
        chk("dec_seq",   {248'd0, fs4}, 0);
        for (int k = 0; k < N; k++)
            chk($sformatf("dec_slot%0d", k), {224'd0, fo4[k*W +: W]}, 4 * k);

        // Reset mid-fill, with a sample presented during the reset cycle.
        step(1'b1, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, k, 1'b0);
        step(1'b1, 1'b1, 77, 1'b1);
        chk("rst_fill",  {252'd0, fl1}, 0);
        chk("rst_valid", {255'd0, fv1}, 0);
        for (int k = 101; k <= 108; k++) step(1'b0, 1'b1, k, 1'b0);
        chk("rst_seq", {248'd0, fs1}, 0);
        chk("rst_ovf", {240'd0, oc1}, 0);
        for (int k = 0; k < N; k++)
            chk($sformatf("rst_slot%0d", k), {224'd0, fo1[k*W +: W]}, k + 101);

        // Randomized traffic against the model: frequent acks first, then starved acks.
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            int ack_pct = (i < 2000) ? 25 : 3;
            bit r  = ($urandom_range(0, 299) == 0);
            bit sv = ($urandom_range(0, 9) < 7);
            bit ak = ($urandom_range(0, 99) < ack_pct);
            step(r, sv, $urandom, ak);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
